fifo_seg_display: RTL and testbench
===================================

# fifo_seg_display

Downstream display stage for the 8-entry FIFO: captures each word the FIFO reads out and shows it on a 4-digit, common-anode, multiplexed seven-segment display, together with a FIFO status character. It sits between the FIFO's data/full/empty outputs and the board's segment and anode pins. It contains a digit-scan state machine, a refresh prescaler, a blink prescaler and an optional sequential binary-to-BCD converter.

## Interface
- memory_width, 8, data word width; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles each digit stays lit; minimum 2.
- BLINK_DIV, 25000000, clock cycles per blink half-period; minimum 2.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset, sampled on posedge clk.
- data_in  in  memory_width  FIFO read data.
- data_valid  in  1  one-cycle pulse; data_in is valid in this cycle.
- full  in  1  FIFO full flag.
- empty  in  1  FIFO empty flag.
- an  out  4  digit anodes, active-low, one-hot-low while scanning.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Shown register: zero-extended to 8 bits. Loaded with data_in on any posedge where data_valid=1. Holds otherwise.
- Digit map, hex mode:
  - digit0 is the low nibble.
  - digit1 is the high nibble.
  - digit2 is blank.
  - digit3 is the status character.
- Status character:
  - 'F' (seg=7'b0001110) when full=1; full has priority if both flags are 1.
  - 'E' (7'b0000110) when empty=1 and full=0.
  - blank (7'b1111111) otherwise.
- Blink: while full=1, digit3 alternates between 'F' and blank every BLINK_DIV cycles. The blink counter runs freely and is cleared only by reset.
- Hex glyphs 0-F use standard patterns; for example 0=7'b1000000 and A=7'b0001000.
- dp is always 1, except on digit0 for one full scan frame (4*REFRESH_DIV cycles) after each load. This is the "new data" tick. A new load restarts the frame.
- Scan FSM states: S_D0 -> S_D1 -> S_D2 -> S_D3 -> S_D0. The state advances when the refresh counter reaches REFRESH_DIV-1, and the counter then wraps to 0.

## Timing
- Reset (rst=0 at a posedge) sets:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - FSM=S_D0; refresh and blink counters=0; shown register=0; BCD busy=0.
- First cycle after reset release: an, seg and dp are driven for S_D0.
- an, seg and dp are registered. They reflect the current FSM state one cycle after each state change, so every digit is lit for exactly REFRESH_DIV cycles.
- Load latency: a data_valid on edge N updates the shown register at edge N. The new glyph appears at the next visit of its digit.
- Reset mid-scan: takes effect at that edge and overrides everything else, including a coincident data_valid.
- data_valid on consecutive cycles: each load overwrites the previous one; the last value wins.

## Configuration
- SEG_DECIMAL_EN defined: the value is shown in decimal.
  - digit2/digit1/digit0 show hundreds/tens/units; digit3 still shows status.
  - Leading zeros on digit2 and digit1 are blanked; the units digit always shows.
  - Each load starts a sequential double-dabble conversion taking exactly 8 cycles. During that time the display keeps showing the previous BCD result. The result commits on the 8th cycle after the load.
  - A data_valid during a conversion restarts the conversion with the new value.
- SEG_DECIMAL_EN undefined: hex mode as above; no converter logic is compiled in.

## Test plan
- Reset hold then release, REFRESH_DIV=4:
  - During reset: an=4'b1111, seg=7'b1111111, dp=1.
  - After release: an steps 1110, 1101, 1011, 0111, each for exactly 4 cycles.
- Hex mode, data_valid with data_in=8'hA5, empty=0, full=0:
  - digit0 shows 5 (7'b0010010), digit1 shows A (7'b0001000), digit2 and digit3 are blank.
  - dp=0 on digit0 for one frame only.
- full=1, empty=1, BLINK_DIV=8: digit3 alternates between 'F' and blank every 8 cycles; 'E' is never shown.
- Two back-to-back pulses with data_in=8'h12 then 8'h34: the display settles on 34. Then assert rst=0 in the middle of a digit: on the next cycle all outputs are blank and the FSM is in S_D0.
- With SEG_DECIMAL_EN, load 8'd7:
  - The display shows units 7, and digit2 and digit1 are blank.
  - Reload with 8'd255: the previous value stays for 8 cycles, then 2, 5, 5 appear.
  - A reload of 8'd100 in the 4th cycle of a conversion finishes with 1, 0, 0.

Source files
------------

// File: rtl/fifo_seg_display.sv
// fifo_seg_display: display stage after the 8-entry FIFO. Captures each word
// read out of the FIFO and shows it on a 4-digit common-anode multiplexed
// seven-segment display, with a FIFO status character on digit3.
//
// Build option: SEG_DECIMAL_EN -- when defined, the word is shown in decimal
// (hundreds/tens/units) through a sequential double-dabble converter;
// otherwise it is shown as two hex digits and no converter is built.
//
// state | meaning
// ------+-------------------------------------------------------
// S_D0  | digit0 lit: low nibble (hex) or units (decimal)
// S_D1  | digit1 lit: high nibble (hex) or tens (decimal)
// S_D2  | digit2 lit: blank (hex) or hundreds (decimal)
// S_D3  | digit3 lit: FIFO status character (F / E / blank)
module fifo_seg_display #(
  parameter int memory_width = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [memory_width-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    full,
  input  logic                    empty,
  output logic [3:0]              an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int TW = $clog2(4 * REFRESH_DIV + 1);

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  // The "new data" dp tick lasts one full scan frame.
  localparam logic [TW-1:0] TICK_LEN     = TW'(4 * REFRESH_DIV);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;

  typedef enum logic [1:0] {S_D0, S_D1, S_D2, S_D3} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] refresh_cnt;
  logic          refresh_done;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    data_ext;
  logic [6:0]    dig0_glyph;
  logic [6:0]    dig1_glyph;
  logic [6:0]    dig2_glyph;
  logic [6:0]    dig3_glyph;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Zero-extend the FIFO word to the 8-bit display width.
  always_comb begin
    data_ext = '0;
    data_ext[memory_width-1:0] = data_in;
  end

  assign refresh_done = (refresh_cnt == REFRESH_LAST);

  // Scan state register and refresh prescaler (wraps when the digit is done).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_D0;
      refresh_cnt <= '0;
    end else begin
      state       <= state_nxt;
      refresh_cnt <= refresh_done ? '0 : refresh_cnt + 1'b1;
    end
  end

  // Next scan state: step to the next digit at the end of each refresh period.
  always_comb begin
    state_nxt = state;
    if (refresh_done) begin
      case (state)
        S_D0:    state_nxt = S_D1;
        S_D1:    state_nxt = S_D2;
        S_D2:    state_nxt = S_D3;
        default: state_nxt = S_D0;
      endcase
    end
  end

  // Free-running blink prescaler; blink_off selects the dark half-period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // New-data tick: reloaded by every load, counts down one frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (data_valid) begin
      tick_cnt <= TICK_LEN;
    end else if (tick_cnt != '0) begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  // Status character; full wins over empty and blinks.
  always_comb begin
    dig3_glyph = GLYPH_BLANK;
    if (full) begin
      dig3_glyph = blink_off ? GLYPH_BLANK : GLYPH_F;
    end else if (empty) begin
      dig3_glyph = GLYPH_E;
    end
  end

`ifdef SEG_DECIMAL_EN
  logic [7:0]  bin_sr;
  logic [11:0] bcd_work;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_step;
  logic [11:0] bcd_shown;
  logic [2:0]  conv_step;
  logic        conv_busy;

  // One double-dabble iteration: add 3 to any BCD digit >= 5, then shift.
  always_comb begin
    bcd_adj = bcd_work;
    if (bcd_work[3:0] > 4'd4) begin
      bcd_adj[3:0] = bcd_work[3:0] + 4'd3;
    end
    if (bcd_work[7:4] > 4'd4) begin
      bcd_adj[7:4] = bcd_work[7:4] + 4'd3;
    end
    if (bcd_work[11:8] > 4'd4) begin
      bcd_adj[11:8] = bcd_work[11:8] + 4'd3;
    end
    bcd_step = {bcd_adj[10:0], bin_sr[7]};
  end

  // Converter: a load (re)starts it; after 8 iterations the result commits,
  // until then the previously committed result stays on the display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      conv_busy <= 1'b0;
      conv_step <= '0;
      bin_sr    <= '0;
      bcd_work  <= '0;
      bcd_shown <= '0;
    end else if (data_valid) begin
      conv_busy <= 1'b1;
      conv_step <= '0;
      bin_sr    <= data_ext;
      bcd_work  <= '0;
    end else if (conv_busy) begin
      bin_sr    <= {bin_sr[6:0], 1'b0};
      bcd_work  <= bcd_step;
      conv_step <= conv_step + 3'd1;
      if (conv_step == 3'd7) begin
        conv_busy <= 1'b0;
        bcd_shown <= bcd_step;
      end
    end
  end

  // Decimal glyphs with leading-zero blanking; units always shown.
  always_comb begin
    dig0_glyph = hex7(bcd_shown[3:0]);
    dig1_glyph = hex7(bcd_shown[7:4]);
    dig2_glyph = hex7(bcd_shown[11:8]);
    if (bcd_shown[11:8] == 4'd0) begin
      dig2_glyph = GLYPH_BLANK;
      if (bcd_shown[7:4] == 4'd0) begin
        dig1_glyph = GLYPH_BLANK;
      end
    end
  end
`else
  logic [7:0] shown;

  // Shown register: last word read out of the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shown <= '0;
    end else if (data_valid) begin
      shown <= data_ext;
    end
  end

  // Hex glyphs; digit2 is unused in hex mode.
  always_comb begin
    dig0_glyph = hex7(shown[3:0]);
    dig1_glyph = hex7(shown[7:4]);
    dig2_glyph = GLYPH_BLANK;
  end
`endif

  // Output decode for the digit selected by the current scan state.
  always_comb begin
    an_nxt  = 4'b1110;
    seg_nxt = dig0_glyph;
    dp_nxt  = (tick_cnt == '0);
    case (state)
      S_D1: begin
        an_nxt  = 4'b1101;
        seg_nxt = dig1_glyph;
        dp_nxt  = 1'b1;
      end
      S_D2: begin
        an_nxt  = 4'b1011;
        seg_nxt = dig2_glyph;
        dp_nxt  = 1'b1;
      end
      S_D3: begin
        an_nxt  = 4'b0111;
        seg_nxt = dig3_glyph;
        dp_nxt  = 1'b1;
      end
      default: begin
        an_nxt  = 4'b1110;
        seg_nxt = dig0_glyph;
        dp_nxt  = (tick_cnt == '0);
      end
    endcase
  end

  // Registered pin drivers; dark during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= GLYPH_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_seg_display.sv
`timescale 1ns/1ps
module tb_fifo_seg_display;

  localparam int MW = 8;
  localparam int RD = 4;
  // BLINK_DIV of 8 would equal the 16-cycle scan frame, so digit3 would always
  // land on the same blink phase; 16 makes successive digit3 visits alternate.
  localparam int BD = 16;

  localparam logic [6:0] G_BL = 7'b1111111;
  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] G5   = 7'b0010010;
  localparam logic [6:0] G7   = 7'b1111000;
  localparam logic [6:0] GA   = 7'b0001000;
  localparam logic [6:0] GF   = 7'b0001110;
  localparam logic [6:0] GE   = 7'b0000110;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [MW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          full = 1'b0;
  logic          empty = 1'b0;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;

  fifo_seg_display #(
    .memory_width(MW),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .full      (full),
    .empty     (empty),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [63:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rel   = 0;   // edge at which reset was first sampled released

  // Monitor: compare DUT pins against every expectation due at this edge.
  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0 && q[0].e <= cyc) begin
      x = q.pop_front();
      n_vec++;
      if (x.e < cyc) begin
        n_err++;
        $display("FAIL %s edge %0d: not checked in time (now edge %0d)", x.tag, x.e, cyc);
      end else if (an !== x.an || seg !== x.seg || dp !== x.dp) begin
        n_err++;
        $display("FAIL %s edge %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 x.tag, x.e, an, seg, dp, x.an, x.seg, x.dp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_rst(input int e);
    exp_t x;
    x.e = e; x.an = 4'b1111; x.seg = G_BL; x.dp = 1'b1; x.tag = "reset";
    q.push_back(x);
  endtask

  // Expected pins for edges from..to: scan position from rel, digit3 blinks
  // when 'blink', dp low on digit0 for one frame after the load at load_e.
  task automatic expect_span(input int from, input int to,
                             input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3,
                             input logic blink, input int load_e,
                             input logic [63:0] tag);
    for (int e = from; e <= to; e++) begin
      int   d;
      exp_t x;
      d     = ((e - rel) / RD) % 4;
      x.e   = e;
      x.an  = ~(4'b0001 << d);
      x.tag = tag;
      case (d)
        0:       x.seg = g0;
        1:       x.seg = g1;
        2:       x.seg = g2;
        default: x.seg = blink ? ((((e - rel) / BD) % 2 == 0) ? GF : G_BL) : g3;
      endcase
      x.dp = (d == 0 && e > load_e && e <= load_e + 4 * RD) ? 1'b0 : 1'b1;
      q.push_back(x);
    end
  endtask

  initial begin
    int w;
    // Reset held over edges 1..3, released from edge 4.
    expect_rst(1); expect_rst(2); expect_rst(3);
    step(3);
    rst = 1'b1;
    rel = 4;
`ifdef SEG_DECIMAL_EN
    expect_span(4, 19, G0, G_BL, G_BL, G_BL, 1'b0, -100, "idle");
    step(16);
    // Load 7 at edge 20; commits at edge 28, visible from 29.
    data_in = 8'd7; data_valid = 1'b1;
    expect_span(20, 28, G0, G_BL, G_BL, G_BL, 1'b0, 20, "dec7old");
    expect_span(29, 43, G7, G_BL, G_BL, G_BL, 1'b0, 20, "dec7");
    step(1);
    data_valid = 1'b0;
    step(23);
    // Reload 255 at edge 44; 7 stays through edge 52.
    data_in = 8'd255; data_valid = 1'b1;
    expect_span(44, 52, G7, G_BL, G_BL, G_BL, 1'b0, 44, "dec255o");
    expect_span(53, 67, G5, G5, G2, G_BL, 1'b0, 44, "dec255");
    step(1);
    data_valid = 1'b0;
    step(23);
    // 42 at edge 68, then 100 at edge 72 (4th conversion cycle): 255 stays
    // until the restarted conversion commits at edge 80.
    data_in = 8'd42; data_valid = 1'b1;
    expect_span(68, 72, G5, G5, G2, G_BL, 1'b0, 68, "decrst0");
    expect_span(73, 80, G5, G5, G2, G_BL, 1'b0, 72, "decrst1");
    expect_span(81, 96, G0, G0, G1, G_BL, 1'b0, 72, "dec100");
    step(1);
    data_valid = 1'b0;
    step(3);
    data_in = 8'd100; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(24);
`else
    expect_span(4, 35, G0, G0, G_BL, G_BL, 1'b0, -100, "idle");
    step(32);
    // Load A5 at edge 36 (start of a frame).
    expect_span(36, 36, G0, G0, G_BL, G_BL, 1'b0, -100, "preA5");
    data_in = 8'hA5; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    expect_span(37, 76, G5, GA, G_BL, G_BL, 1'b0, 36, "hexA5");
    step(40);
    // Both flags from edge 77: F blinks, E never shown.
    full = 1'b1; empty = 1'b1;
    expect_span(77, 124, G5, GA, G_BL, G_BL, 1'b1, 36, "blink");
    step(48);
    // Back-to-back loads 12 (edge 125) then 34 (edge 126).
    full = 1'b0; empty = 1'b0;
    data_in = 8'h12; data_valid = 1'b1;
    expect_span(125, 125, G5, GA, G_BL, G_BL, 1'b0, 36, "b2b0");
    step(1);
    data_in = 8'h34;
    expect_span(126, 126, G2, G1, G_BL, G_BL, 1'b0, 125, "b2b1");
    step(1);
    data_valid = 1'b0;
    expect_span(127, 148, G4, G3, G_BL, G_BL, 1'b0, 126, "b2b34");
    step(22);
    // Reset in the middle of digit0 with a coincident load at edge 149.
    rst = 1'b0; data_in = 8'hFF; data_valid = 1'b1;
    expect_rst(149); expect_rst(150);
    step(1);
    data_valid = 1'b0;
    step(1);
    rst = 1'b1;
    rel = 151;
    expect_span(151, 166, G0, G0, G_BL, G_BL, 1'b0, -100, "midrst");
    step(16);
    empty = 1'b1;
    expect_span(167, 182, G0, G0, G_BL, GE, 1'b0, -100, "empty");
    step(16);
`endif
    w = 0;
    while (q.size() > 0 && w < 50) begin
      step(1);
      w++;
    end
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
